// File: rtl/vga_capture_pkg.sv
// Shared definitions for the VGA capture path.
// State encoding, default geometry and CRC-16-CCITT constants.
package vga_capture_pkg;

  typedef enum logic {
    WAIT_VSYNC = 1'b0,
    CAPTURE    = 1'b1
  } state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int          CNT_W   = 12;
  localparam logic [11:0] CNT_MAX = 12'hFFF;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic logic [11:0] sat_inc(
    input logic [11:0] v
  );
    return (v == CNT_MAX) ? v : v + 12'd1;
  endfunction

  // MSB-first over r, g, b: one pixel folds in as 24 serial bits
  function automatic logic [15:0] crc16_step24(
    input logic [15:0] c,
    input logic [23:0] d
  );
    logic [15:0] n;
    logic        fb;
    n = c;
    for (int i = 23; i >= 0; i--) begin
      fb = n[15] ^ d[i];
      n  = {n[14:0], 1'b0};
      if (fb) n = n ^ CRC_POLY;
    end
    return n;
  endfunction

endpackage

// File: rtl/vga_capture_crc16.sv
// Running CRC-16-CCITT over captured pixels, one pixel per cycle.
// The frame value is latched when a frame completes correctly.
module vga_crc16
  import vga_capture_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        init,
  input  logic        en,
  input  logic [23:0] data,
  input  logic        latch,
  output logic [15:0] crc
);

  logic [15:0] run;
  logic [15:0] run_nxt;

  always_comb begin
    run_nxt = run;
    if (en) run_nxt = crc16_step24(run, data);
  end

  // latch sees run_nxt so the last pixel of the frame is included
  always_ff @(posedge clk) begin
    if (!clrn) begin
      run <= CRC_INIT;
      crc <= '0;
    end else begin
      run <= init ? CRC_INIT : run_nxt;
      if (latch) crc <= run_nxt;
    end
  end

endmodule

// File: rtl/vga_capture.sv
// VGA stream capture into a linear frame buffer with geometry checking.
// Optional frame CRC is built when VGA_CAPTURE_CRC_EN is defined.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   ADDR_W   = 19,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              valid,
  input  logic [7:0]        vga_r,
  input  logic [7:0]        vga_g,
  input  logic [7:0]        vga_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              frame_done,
  output logic              locked,
  output logic              err_line,
  output logic              err_frame,
  output logic [15:0]       frame_crc
);

  localparam logic [11:0]       H12 = 12'(H_ACTIVE);
  localparam logic [11:0]       V12 = 12'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] HA  = ADDR_W'(H_ACTIVE);

  logic        s_hs, s_vs, s_valid;
  logic        p_hs, p_vs;
  logic [23:0] s_rgb;

  state_t            state, state_n;
  logic [11:0]       x, x_n;
  logic [11:0]       y, y_n;
  logic [ADDR_W-1:0] lb, lb_n;
  logic              seen, seen_n;
  logic              err_seen, err_seen_n;

  logic              wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [23:0]       wr_data_n;
  logic              done_n, eline_n, eframe_n, locked_n;

  logic hs_edge, vs_edge, pix;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      s_hs    <= ~SYNC_POL;
      s_vs    <= ~SYNC_POL;
      p_hs    <= ~SYNC_POL;
      p_vs    <= ~SYNC_POL;
      s_valid <= 1'b0;
      s_rgb   <= '0;
    end else begin
      s_hs    <= hsync;
      s_vs    <= vsync;
      p_hs    <= s_hs;
      p_vs    <= s_vs;
      s_valid <= valid;
      s_rgb   <= {vga_r, vga_g, vga_b};
    end
  end

  assign hs_edge = (s_hs == SYNC_POL) && (p_hs != SYNC_POL);
  assign vs_edge = (s_vs == SYNC_POL) && (p_vs != SYNC_POL);
  assign pix     = s_valid && (s_hs != SYNC_POL) && (s_vs != SYNC_POL);

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    lb_n       = lb;
    seen_n     = seen;
    err_seen_n = err_seen;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    done_n     = 1'b0;
    eline_n    = 1'b0;
    eframe_n   = 1'b0;
    locked_n   = locked;
    unique case (state)
      WAIT_VSYNC: begin
        if (vs_edge) begin
          state_n    = CAPTURE;
          x_n        = '0;
          y_n        = '0;
          lb_n       = '0;
          seen_n     = 1'b0;
          err_seen_n = 1'b0;
        end
      end
      CAPTURE: begin
        if (pix) begin
          if (x < H12 && y < V12) begin
            wr_en_n   = 1'b1;
            wr_addr_n = lb + ADDR_W'(x);
            wr_data_n = s_rgb;
          end
          x_n    = sat_inc(x);
          seen_n = 1'b1;
        end
        // line end is resolved before any frame check in the same cycle
        if (hs_edge) begin
          if (seen) begin
            eline_n = (x != H12);
            y_n     = sat_inc(y);
            lb_n    = lb + HA;
            seen_n  = 1'b0;
          end
          x_n = '0;
        end
        if (eline_n) locked_n = 1'b0;
        err_seen_n = err_seen | eline_n;
        if (vs_edge) begin
          if (y_n == V12 && !err_seen_n) begin
            done_n   = 1'b1;
            locked_n = 1'b1;
          end else if (y_n != V12) begin
            eframe_n = 1'b1;
            locked_n = 1'b0;
          end else begin
            locked_n = 1'b0;
          end
          x_n        = '0;
          y_n        = '0;
          lb_n       = '0;
          seen_n     = 1'b0;
          err_seen_n = 1'b0;
        end
      end
      default: state_n = WAIT_VSYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state      <= WAIT_VSYNC;
      x          <= '0;
      y          <= '0;
      lb         <= '0;
      seen       <= 1'b0;
      err_seen   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      lb         <= lb_n;
      seen       <= seen_n;
      err_seen   <= err_seen_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      frame_done <= done_n;
      err_line   <= eline_n;
      err_frame  <= eframe_n;
      locked     <= locked_n;
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  vga_crc16 u_crc (
    .clk   (clk),
    .clrn  (clrn),
    .init  (vs_edge),
    .en    (wr_en),
    .data  (wr_data),
    .latch (done_n),
    .crc   (frame_crc)
  );
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
Receive-side counterpart of vga_ctrl. It samples a VGA pixel stream (hsync, vsync, valid, vga_r/g/b), recovers the pixel coordinates, and writes each active pixel into a linear frame buffer. The buffer address is y*H_ACTIVE + x, the same layout the mem frame-buffer model reads. It also checks frame geometry, so it serves both as a loopback checker for vga_ctrl and as a capture path into simulation memory.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low, matching vga_ctrl)

Ports:
clk  in  1  pixel clock
clrn  in  1  synchronous active-low reset
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
valid  in  1  pixel-data-valid (active video)
vga_r  in  8  red
vga_g  in  8  green
vga_b  in  8  blue
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  24  {r,g,b}
frame_done  out  1  one-cycle pulse: a complete, correct frame was captured
locked  out  1  high after the first correct frame; cleared by any error
err_line  out  1  one-cycle pulse: a line had a pixel count other than H_ACTIVE
err_frame  out  1  one-cycle pulse: a frame had a line count other than V_ACTIVE
frame_crc  out  16  CRC of the last completed frame (see Optional Feature)

Behaviour:
- Reset is synchronous and active-low. Reset is decided as one clock, named clk, with clrn as the reset port, synchronous and active-low.
- While clrn=0 at a clk edge: all outputs 0; x, y and line_base cleared; state goes to WAIT_VSYNC. This also applies mid-frame; capture restarts at the next vsync assertion.
- All inputs are registered once (stage S1). The previous hsync/vsync values are also held, for edge detection.
- A sync assertion edge is a transition from deasserted to SYNC_POL level.
- States:
  - WAIT_VSYNC: no writes. On a vsync assertion edge, go to CAPTURE and clear x, y, line_base.
  - CAPTURE: on each S1 cycle with valid=1 and sync deasserted:
    - If x<H_ACTIVE and y<V_ACTIVE, write pixel (x,y); otherwise the pixel is dropped but still counted.
    - x increments and saturates at 2^12-1.
    - line_seen is set.
- Write timing:
  - wr_en, wr_addr and wr_data are registered, one cycle after S1. Total latency from input pin to wr_* is 2 cycles.
  - wr_addr = line_base + x. line_base advances by H_ACTIVE at each counted line end, so no multiplier is used.
- hsync assertion edge in CAPTURE:
  - If line_seen: pulse err_line if x!=H_ACTIVE; then y increments (saturating), line_base += H_ACTIVE, and line_seen clears.
  - x always clears.
  - Edges with line_seen=0 (blanking lines) do nothing else.
- vsync assertion edge in CAPTURE:
  - If y==V_ACTIVE and no err_line occurred this frame: pulse frame_done and set locked.
  - Else if y!=V_ACTIVE: pulse err_frame and clear locked.
  - Else (correct line count but an err_line occurred): clear locked; no frame_done.
  - In every case, clear x, y and line_base and stay in CAPTURE.
- Any err_line also clears locked in the same cycle.
- Simultaneous hsync and vsync edges in one cycle: line-end processing happens first. The final line counts toward y before the frame check.
- valid=1 while hsync or vsync is asserted: ignored, with no count and no write.
- frame_done, err_line and err_frame are emitted in the cycle after the detecting S1 edge and are single-cycle.

Optional Feature:
VGA_CAPTURE_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) is updated over wr_data (bytes r, g, b, in that order) on every wr_en.
  - The running CRC reinitialises at each vsync edge in CAPTURE.
  - It is latched into frame_crc at the same cycle as frame_done; frame_crc is 0 after reset.
- Not defined: frame_crc is tied to 16'h0000 and no CRC logic is built.

Decomposition:
- Shared package/header vga_defs:
  - state encoding (WAIT_VSYNC=0, CAPTURE=1)
  - default H_ACTIVE/V_ACTIVE
  - CRC polynomial and init constants
- One natural sub-module: vga_crc16, a 24-bit-per-cycle combinational CRC step plus its register, instantiated only under VGA_CAPTURE_CRC_EN.

Test Plan:
All scenarios use H_ACTIVE=8, V_ACTIVE=4.
- Reset mid-line: clrn=0 for 1 cycle while valid=1 → next cycle all outputs 0; no wr_en until a vsync edge plus a valid pixel.
- Clean frame: vsync edge, then 4 lines of 8 valid pixels each, then vsync edge → 32 writes at addresses 0..31 with data matching the inputs (2-cycle latency), one frame_done pulse, locked=1.
- Short line: line 2 has 7 pixels → err_line pulse at its hsync edge; next vsync gives no frame_done and locked=0; the addresses of line 3 start at 24.
- Long frame: 5 active lines → err_frame pulse, locked=0; line 4's pixels are never written (wr_en stays 0 for them).
- Simultaneous edges: the last line's hsync edge coincides with the vsync edge → frame_done asserted (y counted as 4).
- CRC (macro defined): all 32 pixels = 24'h000000 → frame_crc equals the reference CRC-16-CCITT of 96 zero bytes. With the macro undefined → frame_crc=0.
